// File: rtl/axi_ctrl_pkg.sv
// Shared constants and decode types for the accelerator AXI4-Lite control slave.
package axi_ctrl_pkg;

  localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
  localparam logic [31:0] ADDR_IER    = 32'h0000_0008;
  localparam logic [31:0] ADDR_ENABLE = 32'h0000_0040;
  localparam logic [31:0] ADDR_WEIGHT = 32'h0000_0044;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_BUSY  = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_IER,
    SEL_ENABLE,
    SEL_WEIGHT
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [7:0] idx;
  } reg_dec_t;

endpackage

// File: rtl/axi_lite_ctrl_slave_if.sv
// AXI4-Lite bus bundle (32-bit data/address) with master and slave views.
interface axi_lite_ctrl_slave_if;

  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite channel handshakes: independent AW/W latching, B response, registered R path.
// Presents a single-cycle write strobe and read request to the register file.
module axi_lite_slave_if
  import axi_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  axi_lite_ctrl_slave_if.slave bus,
  output logic                 wr_en,
  output logic [31:0]          wr_addr,
  output logic [31:0]          wr_data,
  output logic [3:0]           wr_strb,
  input  logic                 wr_err,
  output logic                 rd_en,
  output logic [31:0]          rd_addr,
  input  logic [31:0]          rd_data,
  input  logic                 rd_err
);

  logic        aw_full, w_full;
  logic        aw_full_nx, w_full_nx, rvalid_nx;
  logic [31:0] awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = bus.AWVALID & bus.AWREADY;
  assign w_hs  = bus.WVALID  & bus.WREADY;
  assign b_hs  = bus.BVALID  & bus.BREADY;
  assign ar_hs = bus.ARVALID & bus.ARREADY;
  assign r_hs  = bus.RVALID  & bus.RREADY;

  // Commit on the edge where the second half arrives; BVALID gates repeats.
  assign wr_en   = !bus.BVALID && (aw_full || aw_hs) && (w_full || w_hs);
  assign wr_addr = aw_full ? awaddr_q : bus.AWADDR;
  assign wr_data = w_full  ? wdata_q  : bus.WDATA;
  assign wr_strb = w_full  ? wstrb_q  : bus.WSTRB;

  assign rd_en   = ar_hs;
  assign rd_addr = bus.ARADDR;

  always_comb begin
    aw_full_nx = aw_full;
    w_full_nx  = w_full;
    rvalid_nx  = bus.RVALID;
    if (aw_hs) aw_full_nx = 1'b1;
    if (w_hs)  w_full_nx  = 1'b1;
    if (b_hs) begin
      aw_full_nx = 1'b0;
      w_full_nx  = 1'b0;
    end
    if (ar_hs)     rvalid_nx = 1'b1;
    else if (r_hs) rvalid_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bus.AWREADY <= 1'b0;
      bus.WREADY  <= 1'b0;
      bus.BVALID  <= 1'b0;
      bus.BRESP   <= RESP_OKAY;
      bus.ARREADY <= 1'b0;
      bus.RVALID  <= 1'b0;
      bus.RDATA   <= '0;
      bus.RRESP   <= RESP_OKAY;
    end else begin
      aw_full     <= aw_full_nx;
      w_full      <= w_full_nx;
      bus.AWREADY <= !aw_full_nx;
      bus.WREADY  <= !w_full_nx;
      if (aw_hs) awaddr_q <= bus.AWADDR;
      if (w_hs) begin
        wdata_q <= bus.WDATA;
        wstrb_q <= bus.WSTRB;
      end
      if (wr_en) begin
        bus.BVALID <= 1'b1;
        bus.BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (b_hs) begin
        bus.BVALID <= 1'b0;
      end
      bus.ARREADY <= !rvalid_nx;
      bus.RVALID  <= rvalid_nx;
      if (ar_hs) begin
        bus.RDATA <= rd_data;
        bus.RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: rtl/axi_lite_ctrl_slave.sv
// Accelerator control register file: CTRL start/done, STATUS busy counter, ENABLE, WEIGHTs.
// Optional macro AXI_CTRL_IRQ_EN adds the IER register at 0x08 and the irq output.
module axi_lite_ctrl_slave
  import axi_ctrl_pkg::*;
#(
  parameter int NUM_WEIGHTS = 10,
  parameter int WEIGHT_W    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  axi_lite_ctrl_slave_if.slave            bus,
  output logic                            acc_enable,
  output logic [NUM_WEIGHTS*WEIGHT_W-1:0] acc_weights,
  output logic                            acc_start,
  input  logic                            acc_done
`ifdef AXI_CTRL_IRQ_EN
  ,
  output logic                            irq
`endif
);

  logic        wr_en, wr_err, rd_en, rd_err;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [3:0]  wr_strb;
  reg_dec_t    wr_dec, rd_dec;

  logic                start_q, busy_q, done_q, enable_q;
  logic [31:0]         status_q;
  logic [WEIGHT_W-1:0] weight_q [NUM_WEIGHTS];
  logic [31:0]         ctrl_rd;
  logic                ctrl_wr;
  logic                unused_bits;

`ifdef AXI_CTRL_IRQ_EN
  logic ier_q;
`endif

  axi_lite_slave_if u_if (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_err  (wr_err),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_err  (rd_err)
  );

  function automatic reg_dec_t decode(input logic [31:0] addr);
    reg_dec_t    d;
    logic [31:0] a;
    logic [31:0] off;
    a     = {addr[31:2], 2'b00};
    off   = a - ADDR_WEIGHT;
    d.sel = SEL_NONE;
    d.idx = '0;
    if (a == ADDR_CTRL)        d.sel = SEL_CTRL;
    else if (a == ADDR_STATUS) d.sel = SEL_STATUS;
`ifdef AXI_CTRL_IRQ_EN
    else if (a == ADDR_IER)    d.sel = SEL_IER;
`endif
    else if (a == ADDR_ENABLE) d.sel = SEL_ENABLE;
    else if (a >= ADDR_WEIGHT && off < 32'(4 * NUM_WEIGHTS)) begin
      d.sel = SEL_WEIGHT;
      d.idx = 8'(off >> 2);
    end
    return d;
  endfunction

  assign wr_dec      = decode(wr_addr);
  assign rd_dec      = decode(rd_addr);
  assign wr_err      = (wr_dec.sel == SEL_NONE);
  assign rd_err      = (rd_dec.sel == SEL_NONE);
  assign ctrl_wr     = wr_en && (wr_dec.sel == SEL_CTRL) && wr_strb[0];
  assign unused_bits = ^{wr_data, wr_strb};

  assign acc_enable = enable_q;
  for (genvar g = 0; g < NUM_WEIGHTS; g++) begin : g_pack
    assign acc_weights[g*WEIGHT_W +: WEIGHT_W] = weight_q[g];
  end

  always_comb begin
    ctrl_rd             = '0;
    ctrl_rd[CTRL_START] = start_q;
    ctrl_rd[CTRL_DONE]  = done_q;
    ctrl_rd[CTRL_BUSY]  = busy_q;
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (rd_dec.sel)
        SEL_CTRL:   rd_data = ctrl_rd;
        SEL_STATUS: rd_data = status_q;
`ifdef AXI_CTRL_IRQ_EN
        SEL_IER:    rd_data = 32'(ier_q);
`endif
        SEL_ENABLE: rd_data = 32'(enable_q);
        SEL_WEIGHT: begin
          for (int i = 0; i < NUM_WEIGHTS; i++)
            if (rd_dec.idx == 8'(i)) rd_data = 32'(weight_q[i]);
        end
        default: ;
      endcase
    end
  end

  // A pending START launches the job on the following edge; done beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_start <= 1'b0;
      status_q  <= '0;
    end else begin
      acc_start <= 1'b0;
      if (start_q) begin
        acc_start <= 1'b1;
        start_q   <= 1'b0;
        busy_q    <= 1'b1;
      end else if (ctrl_wr && wr_data[CTRL_START] && !busy_q) begin
        start_q <= 1'b1;
      end
      if (acc_done) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else if (ctrl_wr && wr_data[CTRL_DONE]) begin
        done_q <= 1'b0;
      end
      if (start_q)
        status_q <= '0;
      else if (busy_q && status_q != 32'hFFFF_FFFF)
        status_q <= status_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= 1'b0;
      for (int i = 0; i < NUM_WEIGHTS; i++) weight_q[i] <= '0;
    end else if (wr_en) begin
      if (wr_dec.sel == SEL_ENABLE && wr_strb[0]) enable_q <= wr_data[0];
      for (int i = 0; i < NUM_WEIGHTS; i++)
        if (wr_dec.sel == SEL_WEIGHT && wr_dec.idx == 8'(i))
          for (int b = 0; b < WEIGHT_W / 8; b++)
            if (wr_strb[b]) weight_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

`ifdef AXI_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ier_q <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (wr_en && wr_dec.sel == SEL_IER && wr_strb[0]) ier_q <= wr_data[0];
      irq <= done_q & ier_q;
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_ctrl_slave.sv
// Directed bench for axi_lite_ctrl_slave: register access, handshake ordering, start/done, errors.
module tb_axi_lite_ctrl_slave;

  localparam int NUM_WEIGHTS = 10;
  localparam int WEIGHT_W    = 16;

  logic                            clk = 1'b0;
  logic                            reset = 1'b1;
  logic                            acc_enable;
  logic [NUM_WEIGHTS*WEIGHT_W-1:0] acc_weights;
  logic                            acc_start;
  logic                            acc_done = 1'b0;
`ifdef AXI_CTRL_IRQ_EN
  logic                            irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;

  axi_lite_ctrl_slave_if bus ();

  axi_lite_ctrl_slave #(.NUM_WEIGHTS(NUM_WEIGHTS), .WEIGHT_W(WEIGHT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .acc_enable  (acc_enable),
    .acc_weights (acc_weights),
    .acc_start   (acc_start),
    .acc_done    (acc_done)
`ifdef AXI_CTRL_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (acc_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_delay, output logic [1:0] resp);
    int n;
    bit aw_done, w_done, aw_go, w_go;
    bus.AWADDR  = addr;
    bus.AWVALID = 1'b1;
    bus.WDATA   = data;
    bus.WSTRB   = strb;
    bus.WVALID  = (w_delay == 0);
    n = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_go = bus.AWVALID && bus.AWREADY;
      w_go  = bus.WVALID && bus.WREADY;
      @(negedge clk);
      n++;
      if (aw_go) begin bus.AWVALID = 1'b0; aw_done = 1; end
      if (w_go)  begin bus.WVALID  = 1'b0; w_done  = 1; end
      if (!w_done && !w_go && n >= w_delay) bus.WVALID = 1'b1;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b1;
    n = 0;
    while (!bus.BVALID && n < 50) begin @(negedge clk); n++; end
    chk("bvalid_seen", {31'b0, bus.BVALID}, 32'd1);
    resp = bus.BRESP;
    @(negedge clk);
    bus.BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.ARVALID = 1'b0;
    while (!bus.RVALID && n < 50) begin @(negedge clk); n++; end
    chk("rvalid_seen", {31'b0, bus.RVALID}, 32'd1);
    data = bus.RDATA;
    resp = bus.RRESP;
    bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int          n;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_awready", {31'b0, bus.AWREADY}, 32'd0);
    chk("rst_arready", {31'b0, bus.ARREADY}, 32'd0);
    chk("rst_bvalid",  {31'b0, bus.BVALID},  32'd0);
    chk("rst_rvalid",  {31'b0, bus.RVALID},  32'd0);
    chk("rst_start",   {31'b0, acc_start},   32'd0);
    chk("rst_enable",  {31'b0, acc_enable},  32'd0);
    chk("rst_weights", acc_weights[31:0],    32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("awready_up", {31'b0, bus.AWREADY}, 32'd1);
    chk("arready_up", {31'b0, bus.ARREADY}, 32'd1);

    axi_write(32'h44, 32'd1, 4'hF, 0, rsp); chk("w44_bresp", {30'b0, rsp}, 32'd0);
    axi_write(32'h48, 32'd3, 4'hF, 0, rsp); chk("w48_bresp", {30'b0, rsp}, 32'd0);
    chk("acc_w0", {16'b0, acc_weights[15:0]},  32'd1);
    chk("acc_w1", {16'b0, acc_weights[31:16]}, 32'd3);
    axi_read(32'h44, rd, rsp); chk("r44", rd, 32'd1); chk("r44_rresp", {30'b0, rsp}, 32'd0);
    axi_read(32'h48, rd, rsp); chk("r48", rd, 32'd3); chk("r48_rresp", {30'b0, rsp}, 32'd0);
    axi_read(32'h4A, rd, rsp); chk("r4a_lowbits", rd, 32'd3);

    axi_write(32'h4C, 32'h0000_ABCD, 4'hF, 3, rsp);
    chk("late_w_bresp", {30'b0, rsp}, 32'd0);
    chk("late_w_single_b", {31'b0, bus.BVALID}, 32'd0);
    chk("acc_w2", {16'b0, acc_weights[47:32]}, 32'h0000_ABCD);

    axi_write(32'h40, 32'd1, 4'hF, 0, rsp);
    chk("enable_out", {31'b0, acc_enable}, 32'd1);
    axi_read(32'h40, rd, rsp); chk("r_enable", rd, 32'd1);

    axi_write(32'h00, 32'd1, 4'hF, 0, rsp); chk("start_bresp", {30'b0, rsp}, 32'd0);
    axi_read(32'h00, rd, rsp); chk("ctrl_busy", rd, 32'h4);
    chk("start_pulses", start_cnt, 32'd1);
    n = 0;
    while (cyc != start_cyc + 49 && n < 200) begin @(negedge clk); n++; end
    chk("done_timing", {31'b0, cyc == start_cyc + 49}, 32'd1);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    axi_read(32'h00, rd, rsp); chk("ctrl_done", rd, 32'h2);
    axi_read(32'h04, rd, rsp); chk("status_50", rd, 32'd50);
    axi_read(32'h04, rd, rsp); chk("status_hold", rd, 32'd50);

    axi_write(32'h00, 32'd2, 4'hF, 0, rsp);
    axi_read(32'h00, rd, rsp); chk("ctrl_w1c", rd, 32'h0);

    axi_write(32'h00, 32'd1, 4'hF, 0, rsp);
    axi_read(32'h04, rd, rsp); chk("status_clr", {31'b0, rd < 32'd20}, 32'd1);
    axi_write(32'h00, 32'd1, 4'hF, 0, rsp); chk("busy_start_bresp", {30'b0, rsp}, 32'd0);
    repeat (3) @(negedge clk);
    chk("no_2nd_start", start_cnt, 32'd2);
    axi_read(32'h00, rd, rsp); chk("ctrl_busy2", rd, 32'h4);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;

    axi_read(32'h100, rd, rsp);
    chk("unmapped_rdata", rd, 32'd0); chk("unmapped_rresp", {30'b0, rsp}, 32'd2);
    axi_write(32'h100, 32'hFFFF_FFFF, 4'hF, 0, rsp);
    chk("unmapped_bresp", {30'b0, rsp}, 32'd2);
    chk("unmapped_w0", {16'b0, acc_weights[15:0]}, 32'd1);
    chk("unmapped_en", {31'b0, acc_enable}, 32'd1);
`ifndef AXI_CTRL_IRQ_EN
    axi_read(32'h08, rd, rsp); chk("ier_absent_rresp", {30'b0, rsp}, 32'd2);
`endif

    axi_read(32'h6C, rd, rsp); chk("past_last_rresp", {30'b0, rsp}, 32'd2);
    axi_write(32'h68, 32'hDEAD_BEEF, 4'hF, 0, rsp); chk("last_w_bresp", {30'b0, rsp}, 32'd0);
    axi_read(32'h68, rd, rsp); chk("last_w_zext", rd, 32'h0000_BEEF);
    chk("acc_w9", {16'b0, acc_weights[159:144]}, 32'h0000_BEEF);

    axi_write(32'h44, 32'h0000_0102, 4'hF, 0, rsp);
    axi_write(32'h44, 32'h0000_FFFF, 4'b0001, 0, rsp);
    axi_read(32'h44, rd, rsp); chk("strobe_merge", rd, 32'h0000_01FF);

`ifdef AXI_CTRL_IRQ_EN
    axi_write(32'h08, 32'd1, 4'hF, 0, rsp); chk("ier_bresp", {30'b0, rsp}, 32'd0);
    axi_read(32'h08, rd, rsp); chk("ier_read", rd, 32'd1);
    repeat (2) @(negedge clk);
    chk("irq_set", {31'b0, irq}, 32'd1);
    axi_write(32'h00, 32'd2, 4'hF, 0, rsp);
    repeat (2) @(negedge clk);
    chk("irq_clr", {31'b0, irq}, 32'd0);
`endif

    bus.AWADDR  = 32'h44;
    bus.AWVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_bvalid",  {31'b0, bus.BVALID},  32'd0);
    chk("midrst_awready", {31'b0, bus.AWREADY}, 32'd0);
    chk("midrst_w0",      {16'b0, acc_weights[15:0]}, 32'd0);
    chk("midrst_enable",  {31'b0, acc_enable},  32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", {31'b0, bus.AWREADY}, 32'd1);
    chk("post_rst_wready",  {31'b0, bus.WREADY},  32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
